// File: rtl/wb_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_unit_if
// Description : Bundle of ALU result, load issue/response and register-file
//               write signals exchanged with the write-back unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_unit_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        ld_issue_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy_mask;
    logic        resp_err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_rd, ld_funct3, ld_addr_lo,
        output ld_resp_valid, ld_resp_data,
        input  alu_ready, ld_issue_ready,
        input  wr_en, wr_addr, wr_data, busy_mask, resp_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_rd, ld_funct3, ld_addr_lo,
        input  ld_resp_valid, ld_resp_data,
        output alu_ready, ld_issue_ready,
        output wr_en, wr_addr, wr_data, busy_mask, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/wb_unit.sv
`default_nettype none
// ============================================================================
// Module      : wb_unit
// Description : Register-file write-back arbiter merging ALU results and
//               in-order load responses, with a load context queue and a
//               per-register busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_unit #(
    parameter int LDQ_DEPTH = 2
) (
    input  wire logic  clk,
    input  wire logic  rst,
    wb_unit_if.slave   bus
);
    localparam int c_PTR_W = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(LDQ_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [4:0]         r_q_rd  [LDQ_DEPTH];
    logic [2:0]         r_q_f3  [LDQ_DEPTH];
    logic [1:0]         r_q_lo  [LDQ_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_busy;
    logic               r_resp_err;
    logic               r_wr_en;
    logic [4:0]         r_wr_addr;
    logic [31:0]        r_wr_data;

    logic [31:0]        w_busy_eff;
    logic [31:0]        w_busy_next;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_alu_acc;
    logic [4:0]         w_head_rd;
    logic [2:0]         w_head_f3;
    logic [1:0]         w_head_lo;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_ld_data;

    // Readiness is judged against the cleared state while rst is asserted.
    assign w_busy_eff = rst ? 32'd0 : r_busy;
    assign w_full     = !rst && (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);

    assign bus.ld_issue_ready = (!w_full || bus.ld_resp_valid) &&
                                ((bus.ld_rd == 5'd0) || !w_busy_eff[bus.ld_rd]);
    assign bus.alu_ready      = !bus.ld_resp_valid &&
                                ((bus.alu_rd == 5'd0) || !w_busy_eff[bus.alu_rd]);

    assign w_push    = bus.ld_issue && bus.ld_issue_ready;
    assign w_pop     = bus.ld_resp_valid && !w_empty;
    assign w_alu_acc = bus.alu_valid && bus.alu_ready;

    assign w_head_rd = r_q_rd[r_rd_ptr];
    assign w_head_f3 = r_q_f3[r_rd_ptr];
    assign w_head_lo = r_q_lo[r_rd_ptr];

    always_comb begin
        w_byte = 8'd0;
        case (w_head_lo)
            2'd0:    w_byte = bus.ld_resp_data[7:0];
            2'd1:    w_byte = bus.ld_resp_data[15:8];
            2'd2:    w_byte = bus.ld_resp_data[23:16];
            default: w_byte = bus.ld_resp_data[31:24];
        endcase
        w_half = w_head_lo[1] ? bus.ld_resp_data[31:16] : bus.ld_resp_data[15:0];

        w_ld_data = bus.ld_resp_data;
        case (w_head_f3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = bus.ld_resp_data;
        endcase
    end

    // The popped rd is busy and a pushed rd is not, so they never collide.
    always_comb begin
        w_busy_next = r_busy;
        if (w_pop) begin
            w_busy_next[w_head_rd] = 1'b0;
        end
        if (w_push) begin
            w_busy_next[bus.ld_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_wr_ptr] <= bus.ld_rd;
            r_q_f3[r_wr_ptr] <= bus.ld_funct3;
            r_q_lo[r_wr_ptr] <= bus.ld_addr_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_busy     <= 32'd0;
            r_resp_err <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 5'd0;
            r_wr_data  <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_busy <= w_busy_next;
            if (bus.ld_resp_valid && w_empty) begin
                r_resp_err <= 1'b1;
            end

            if (w_pop) begin
                r_wr_en   <= (w_head_rd != 5'd0);
                r_wr_addr <= w_head_rd;
                r_wr_data <= w_ld_data;
            end else if (w_alu_acc) begin
                r_wr_en   <= (bus.alu_rd != 5'd0);
                r_wr_addr <= bus.alu_rd;
                r_wr_data <= bus.alu_data;
            end else begin
                r_wr_en   <= 1'b0;
            end
        end
    end

    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy_mask = r_busy;
    assign bus.resp_err  = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_unit
// Description : Self-checking bench for wb_unit using a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_unit;
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    wr_t  sb [$];

    always #5 clk = ~clk;

    wb_unit_if bus ();

    wb_unit #(.LDQ_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [2:0]  ext_f3  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010, 3'b011};
    logic [1:0]  ext_lo  [7] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd1};
    logic [31:0] ext_in  [7] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h1234_9ABC,
                                 32'h0000_7F00, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    logic [31:0] ext_exp [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_9ABC,
                                 32'h0000_007F, 32'hDEAD_BEEF, 32'hCAFE_F00D};

    // Advance one clock and retire the scoreboard entry due this cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            wr_t e;
            e = sb.pop_front();
            n_checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
                n_errors++;
                $display("FAIL sb_write: got en=%b addr=%0d data=%h, want en=1 addr=%0d data=%h",
                         bus.wr_en, bus.wr_addr, bus.wr_data, e.addr, e.data);
            end
        end else begin
            n_checks++;
            if (bus.wr_en !== 1'b0) begin
                n_errors++;
                $display("FAIL sb_idle: got wr_en=%b addr=%0d, want wr_en=0", bus.wr_en, bus.wr_addr);
            end
        end
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic idle();
        bus.alu_valid     = 1'b0;
        bus.alu_rd        = 5'd0;
        bus.alu_data      = 32'd0;
        bus.ld_issue      = 1'b0;
        bus.ld_rd         = 5'd0;
        bus.ld_funct3     = 3'b010;
        bus.ld_addr_lo    = 2'd0;
        bus.ld_resp_valid = 1'b0;
        bus.ld_resp_data  = 32'd0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
        bus.ld_issue   = 1'b1;
        bus.ld_rd      = rd;
        bus.ld_funct3  = f3;
        bus.ld_addr_lo = lo;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        issue(5'd8, 3'b010, 2'd0);
        step();
        step();
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_wr: got en=%b addr=%0d data=%h, want 0/0/0",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        n_checks++;
        if (bus.busy_mask !== 32'd0 || bus.resp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got busy=%h err=%b, want 0/0", bus.busy_mask, bus.resp_err);
        end
        n_checks++;
        if (bus.ld_issue_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: got ld_rdy=%b alu_rdy=%b, want 1/1",
                     bus.ld_issue_ready, bus.alu_ready);
        end
        rst = 1'b0;
        idle();
        step();
        n_checks++;
        if (bus.busy_mask !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_discard: got busy=%h, want 0", bus.busy_mask);
        end
    endtask

    task automatic test_alu();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'h1234_5678;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL alu_ready: got %b, want 1", bus.alu_ready);
        end
        push_exp(5'd5, 32'h1234_5678);
        step();
        idle();
        step();
        n_checks++;
        if (bus.wr_addr !== 5'd5 || bus.wr_data !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL alu_hold: got addr=%0d data=%h, want 5/12345678", bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic test_load_ext();
        for (int i = 0; i < 7; i++) begin
            issue(5'd7, ext_f3[i], ext_lo[i]);
            #1;
            n_checks++;
            if (bus.ld_issue_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL ext_issue_ready[%0d]: got %b, want 1", i, bus.ld_issue_ready);
            end
            step();
            idle();
            n_checks++;
            if (bus.busy_mask !== 32'h0000_0080) begin
                n_errors++;
                $display("FAIL ext_busy_set[%0d]: got %h, want 00000080", i, bus.busy_mask);
            end
            bus.ld_resp_valid = 1'b1;
            bus.ld_resp_data  = ext_in[i];
            push_exp(5'd7, ext_exp[i]);
            step();
            idle();
            n_checks++;
            if (bus.busy_mask !== 32'd0) begin
                n_errors++;
                $display("FAIL ext_busy_clr[%0d]: got %h, want 0", i, bus.busy_mask);
            end
        end
    endtask

    task automatic test_priority();
        issue(5'd9, 3'b010, 2'd0);
        step();
        idle();
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'hA5A5_0001;
        bus.alu_valid     = 1'b1;
        bus.alu_rd        = 5'd4;
        bus.alu_data      = 32'h0BAD_F00D;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL prio_alu_blocked: got %b, want 0", bus.alu_ready);
        end
        push_exp(5'd9, 32'hA5A5_0001);
        step();
        bus.ld_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL prio_alu_retry: got %b, want 1", bus.alu_ready);
        end
        push_exp(5'd4, 32'h0BAD_F00D);
        step();
        idle();
        step();
    endtask

    task automatic test_full();
        issue(5'd10, 3'b010, 2'd0);
        step();
        issue(5'd11, 3'b010, 2'd0);
        step();
        issue(5'd12, 3'b010, 2'd0);
        #1;
        n_checks++;
        if (bus.ld_issue_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_blocked: got %b, want 0", bus.ld_issue_ready);
        end
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'h1111_000A;
        #1;
        n_checks++;
        if (bus.ld_issue_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL full_pushpop_ready: got %b, want 1", bus.ld_issue_ready);
        end
        push_exp(5'd10, 32'h1111_000A);
        step();
        idle();
        n_checks++;
        if (bus.busy_mask !== 32'h0000_1800) begin
            n_errors++;
            $display("FAIL full_busy: got %h, want 00001800", bus.busy_mask);
        end
        n_checks++;
        if (bus.ld_issue_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_still_full: got %b, want 0", bus.ld_issue_ready);
        end
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'h2222_000B;
        push_exp(5'd11, 32'h2222_000B);
        step();
        bus.ld_resp_data  = 32'h3333_000C;
        push_exp(5'd12, 32'h3333_000C);
        step();
        idle();
        n_checks++;
        if (bus.busy_mask !== 32'd0 || bus.resp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL full_drain: got busy=%h err=%b, want 0/0", bus.busy_mask, bus.resp_err);
        end
    endtask

    task automatic test_hazard();
        issue(5'd3, 3'b010, 2'd0);
        step();
        idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 32'h5555_5555;
        issue(5'd3, 3'b010, 2'd0);
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b0 || bus.ld_issue_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL hazard_rd3: got alu_rdy=%b ld_rdy=%b, want 0/0",
                     bus.alu_ready, bus.ld_issue_ready);
        end
        bus.ld_issue = 1'b0;
        bus.alu_rd   = 5'd0;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL hazard_rd0_ready: got %b, want 1", bus.alu_ready);
        end
        step();
        idle();
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'h0000_0333;
        push_exp(5'd3, 32'h0000_0333);
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            logic [31:0] d;
            d = $urandom;
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(i + 1);
            bus.alu_data  = d;
            push_exp(5'(i + 1), d);
            step();
        end
        idle();
        step();
    endtask

    task automatic test_reset_outstanding();
        issue(5'd6, 3'b010, 2'd0);
        step();
        idle();
        n_checks++;
        if (bus.busy_mask !== 32'h0000_0040) begin
            n_errors++;
            $display("FAIL rst_out_busy: got %h, want 00000040", bus.busy_mask);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'hFFFF_FFFF;
        step();
        idle();
        n_checks++;
        if (bus.resp_err !== 1'b1 || bus.busy_mask !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_out_err: got err=%b busy=%h, want 1/0", bus.resp_err, bus.busy_mask);
        end
        step();
        n_checks++;
        if (bus.resp_err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_sticky: got %b, want 1", bus.resp_err);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (bus.resp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_cleared: got %b, want 0", bus.resp_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_alu();
        test_load_ext();
        test_priority();
        test_full();
        test_hazard();
        test_back_to_back();
        test_reset_outstanding();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
